// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined carry-look-ahead adder/subtractor, one CLA group per stage
module cla_pipe_addsub #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             carry,
   output logic             zero,
   output logic             parity,
   output logic             sign,
   output logic             overflow
);
   localparam int NSTG = WIDTH / GROUP;

   logic [NSTG-1:0]            v_q, v_d;
   logic [NSTG-1:0]            c_q, c_d;
   logic [NSTG-1:0][WIDTH-1:0] x_q, x_d;
   logic [NSTG-1:0][WIDTH-1:0] y_q, y_d;
   logic [NSTG-1:0][WIDTH-1:0] s_q, s_d;
   logic                       zero_q, zero_d;
   logic                       parity_q, parity_d;
   logic                       ovf_q, ovf_d;

   logic                       adv;
   logic [WIDTH-1:0]           src_x, src_y, sum;
   logic [GROUP:0]             grp;

   // Returns {carry_out, sum}; every internal carry is a flat sum of products
   // of generate/propagate terms so nothing ripples inside the group.
   function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] a,
                                                input logic [GROUP-1:0] b,
                                                input logic             ci);
      logic [GROUP-1:0] g, p;
      logic [GROUP:0]   c;
      logic             term;
      g = a & b;
      p = a ^ b;
      c = '0;
      c[0] = ci;
      for (int i = 0; i < GROUP; i++) begin
         c[i+1] = ci;
         for (int j = 0; j <= i; j++) c[i+1] = c[i+1] & p[j];
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int m = j + 1; m <= i; m++) term = term & p[m];
            c[i+1] = c[i+1] | term;
         end
      end
      return {c[GROUP], p ^ c[GROUP-1:0]};
   endfunction

   always_comb begin
      adv      = ~v_q[NSTG-1] | out_ready;
      v_d      = v_q;
      c_d      = c_q;
      x_d      = x_q;
      y_d      = y_q;
      s_d      = s_q;
      zero_d   = zero_q;
      parity_d = parity_q;
      ovf_d    = ovf_q;

      src_x = x;
      src_y = sub ? ~y : y;
      sum   = '0;
      grp   = cla_group(src_x[GROUP-1:0], src_y[GROUP-1:0], sub | cin);
      sum[GROUP-1:0] = grp[GROUP-1:0];
      if (adv) begin
         v_d[0] = in_valid;
         c_d[0] = grp[GROUP];
         x_d[0] = src_x;
         y_d[0] = src_y;
         s_d[0] = sum;
      end

      // Lower sum slices ride along with the operands so the full result lands together.
      for (int k = 1; k < NSTG; k++) begin
         src_x = x_q[k-1];
         src_y = y_q[k-1];
         sum   = s_q[k-1];
         grp   = cla_group(src_x[k*GROUP +: GROUP], src_y[k*GROUP +: GROUP], c_q[k-1]);
         sum[k*GROUP +: GROUP] = grp[GROUP-1:0];
         if (adv) begin
            v_d[k] = v_q[k-1];
            c_d[k] = grp[GROUP];
            x_d[k] = src_x;
            y_d[k] = src_y;
            s_d[k] = sum;
         end
      end

      if (adv) begin
         zero_d   = (sum == '0);
         parity_d = ~^sum;
         ovf_d    = (src_x[WIDTH-1] & src_y[WIDTH-1] & ~sum[WIDTH-1]) |
                    (~src_x[WIDTH-1] & ~src_y[WIDTH-1] & sum[WIDTH-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q      <= '0;
         c_q      <= '0;
         x_q      <= '0;
         y_q      <= '0;
         s_q      <= '0;
         zero_q   <= 1'b0;
         parity_q <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         v_q      <= v_d;
         c_q      <= c_d;
         x_q      <= x_d;
         y_q      <= y_d;
         s_q      <= s_d;
         zero_q   <= zero_d;
         parity_q <= parity_d;
         ovf_q    <= ovf_d;
      end
   end

   assign in_ready  = adv;
   assign out_valid = v_q[NSTG-1];
   assign z         = s_q[NSTG-1];
   assign carry     = c_q[NSTG-1];
   assign zero      = zero_q;
   assign parity    = parity_q;
   assign sign      = s_q[NSTG-1][WIDTH-1];
   assign overflow  = ovf_q;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb/tb_cla_pipe_addsub.sv - directed bench for cla_pipe_addsub at default, 32/8 and 8/8 widths
module tb_cla_pipe_addsub;
   logic        clk;
   logic        rst_n;

   logic        in_valid, in_ready, sub, cin, out_valid, out_ready;
   logic [15:0] x, y, z;
   logic        carry, zero, parity, sign, overflow;
   logic [4:0]  flg;
   logic [20:0] res;

   logic        in_valid32, in_ready32, out_valid32;
   logic [31:0] x32, y32, z32;
   logic        carry32, zero32, parity32, sign32, overflow32;

   logic        in_valid8, in_ready8, out_valid8;
   logic [7:0]  x8, y8, z8;
   logic        carry8, zero8, parity8, sign8, overflow8;

   int          passed, total, fails;
   logic [15:0] sx [8];
   logic [15:0] sy [8];
   logic        ss [8];
   logic        sc [8];
   logic [20:0] got [$];
   logic [20:0] held;
   logic        stalled;
   int          nacc, cnt;

   assign flg = {carry, zero, parity, sign, overflow};
   assign res = {z, flg};

   cla_pipe_addsub dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .z(z), .carry(carry), .zero(zero), .parity(parity), .sign(sign), .overflow(overflow)
   );

   cla_pipe_addsub #(.WIDTH(32), .GROUP(8)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
      .x(x32), .y(y32), .sub(1'b0), .cin(1'b0), .out_valid(out_valid32), .out_ready(1'b1),
      .z(z32), .carry(carry32), .zero(zero32), .parity(parity32), .sign(sign32),
      .overflow(overflow32)
   );

   cla_pipe_addsub #(.WIDTH(8), .GROUP(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .x(x8), .y(y8), .sub(1'b0), .cin(1'b0), .out_valid(out_valid8), .out_ready(1'b1),
      .z(z8), .carry(carry8), .zero(zero8), .parity(parity8), .sign(sign8),
      .overflow(overflow8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer add of the effective operands, flags from the 17-bit sum.
   function automatic logic [20:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic s, input logic ci);
      logic [15:0] ye;
      logic [16:0] r;
      logic        ov;
      ye = s ? ~b : b;
      r  = {1'b0, a} + {1'b0, ye} + {16'd0, (s | ci)};
      ov = (a[15] == ye[15]) && (r[15] != a[15]);
      return {r[15:0], r[16], (r[15:0] == 16'd0), ~^r[15:0], r[15], ov};
   endfunction

   task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic s, input logic ci, input logic [15:0] ez,
                           input logic [4:0] ef);
      in_valid = 1'b1; x = a; y = b; sub = s; cin = ci;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
      tick();
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_z"}, {16'd0, z}, {16'd0, ez});
      chk({tag, "_flags"}, {27'd0, flg}, {27'd0, ef});
   endtask

   initial begin
      passed = 0; total = 0; fails = 0;
      sx = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0000, 16'h7FFF, 16'hAAAA, 16'h0F0F, 16'hC350};
      sy = '{16'h4321, 16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF, 16'h5555, 16'hF0F0, 16'h3CB0};
      ss = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      sc = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; sub = 1'b0; cin = 1'b0;
      in_valid32 = 1'b0; x32 = '0; y32 = '0; in_valid8 = 1'b0; x8 = '0; y8 = '0;
      tick();
      tick();
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_z", {16'd0, z}, 32'd0);
      chk("reset_flags", {27'd0, flg}, 32'h04);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      tick();

      directed("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 5'b00011);
      directed("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 5'b11100);
      directed("add_cin",   16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 5'b11100);
      directed("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 5'b00010);
      directed("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 5'b10001);

      // Back-to-back stream: result j-3 is visible after the j-th edge of the burst.
      for (int j = 0; j < 11; j++) begin
         in_valid = (j < 8);
         if (j < 8) begin
            x = sx[j]; y = sy[j]; sub = ss[j]; cin = sc[j];
         end
         tick();
         if (j >= 3) begin
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_res", {11'd0, res}, {11'd0, model(sx[j-3], sy[j-3], ss[j-3], sc[j-3])});
         end else begin
            chk("stream_lat", {31'd0, out_valid}, 32'd0);
         end
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drained", {31'd0, out_valid}, 32'd0);

      // Backpressure: out_ready low for 5 cycles with the pipeline full.
      nacc = 0; stalled = 1'b0; held = '0;
      got.delete();
      for (int t = 0; t < 40 && got.size() < 6; t++) begin
         out_ready = !(t >= 5 && t < 10);
         in_valid  = (nacc < 6);
         if (nacc < 6) begin
            x = sx[nacc+2]; y = sy[nacc+2]; sub = ss[nacc+2]; cin = sc[nacc+2];
         end
         #1;
         if (stalled) begin
            chk("stall_valid_hold", {31'd0, out_valid}, 32'd1);
            chk("stall_res_hold", {11'd0, res}, {11'd0, held});
         end
         if (out_valid && !out_ready) chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         stalled = out_valid & ~out_ready;
         held    = res;
         if (out_valid && out_ready) got.push_back(res);
         if (in_valid && in_ready) nacc++;
         tick();
      end
      chk("stall_count", got.size(), 32'd6);
      for (int i = 0; i < got.size(); i++)
         chk("stall_order", {11'd0, got[i]}, {11'd0, model(sx[i+2], sy[i+2], ss[i+2], sc[i+2])});

      // Reset with three operations in flight.
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (6) tick();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; x = sx[i]; y = sy[i]; sub = ss[i]; cin = sc[i];
         tick();
      end
      in_valid = 1'b0; rst_n = 1'b0;
      tick();
      chk("rst_flight_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_flight_z", {16'd0, z}, 32'd0);
      chk("rst_flight_flags", {27'd0, flg}, 32'h04);
      rst_n = 1'b1;
      cnt = 0;
      repeat (8) begin
         tick();
         if (out_valid) cnt++;
      end
      chk("rst_flight_leak", cnt, 32'd0);

      // WIDTH=32, GROUP=8: four stages.
      in_valid32 = 1'b1; x32 = 32'hFFFF_FFFF; y32 = 32'h0000_0001;
      tick();
      in_valid32 = 1'b0;
      tick();
      tick();
      chk("w32_early", {31'd0, out_valid32}, 32'd0);
      tick();
      chk("w32_valid", {31'd0, out_valid32}, 32'd1);
      chk("w32_z", z32, 32'd0);
      chk("w32_carry_zero", {30'd0, carry32, zero32}, 32'd3);

      // WIDTH=8, GROUP=8: single stage.
      in_valid8 = 1'b1; x8 = 8'h7F; y8 = 8'h01;
      tick();
      in_valid8 = 1'b0;
      chk("w8_valid", {31'd0, out_valid8}, 32'd1);
      chk("w8_z", {24'd0, z8}, 32'h80);
      chk("w8_flags", {27'd0, carry8, zero8, parity8, sign8, overflow8}, 32'h03);
      tick();
      chk("w8_bubble", {31'd0, out_valid8}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
